// File: rtl/csr_file_pkg.sv
// Shared types and constants for the RV32 machine-mode CSR file.
package csr_file_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_t;

    localparam int          MSTATUS_MIE_BIT  = 3;
    localparam int          MSTATUS_MPIE_BIT = 7;
    localparam logic [31:0] MIE_WMASK        = 32'h0000_0888;

    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_TIME      = 12'hC01;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    function automatic logic [31:0] csr_wval(csr_op_t op, logic [31:0] old, logic [31:0] wd);
        case (op)
            CSR_RW:  return wd;
            CSR_RS:  return old | wd;
            CSR_RC:  return old & ~wd;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q, cnt_d;

    // A write to either half suppresses this cycle's increment.
    always_comb begin
        cnt_d = cnt_q;
        if (we_lo)
            cnt_d[31:0] = wdata;
        else if (we_hi)
            cnt_d[63:32] = wdata;
        else if (inc)
            cnt_d = cnt_q + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// RV32 machine-mode CSR file with trap/mret handling and 64-bit counters.
// Define CSR_ZICNTR_EN to add the read-only user counter aliases.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic        csr_wen,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        instret_pulse,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    input  logic        mret_req,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_o,
    output logic        mstatus_mie
);

    logic        mie_bit_q, mie_bit_d;
    logic        mpie_bit_q, mpie_bit_d;
    logic [31:2] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:2] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mie_q, mie_d;

    logic [63:0] mcycle, minstret;
    logic [31:0] old_val, wval, mstatus_val;
    logic        impl, wr;

    assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_bit_q, 3'b0, mie_bit_q, 3'b0};

    always_comb begin
        impl    = 1'b1;
        old_val = '0;
        case (csr_addr)
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID, ADDR_MIP: old_val = '0;
            ADDR_MHARTID:   old_val = HART_ID;
            ADDR_MISA:      old_val = MISA_VALUE;
            ADDR_MSTATUS:   old_val = mstatus_val;
            ADDR_MIE:       old_val = mie_q;
            ADDR_MTVEC:     old_val = {mtvec_q, 2'b00};
            ADDR_MSCRATCH:  old_val = mscratch_q;
            ADDR_MEPC:      old_val = {mepc_q, 2'b00};
            ADDR_MCAUSE:    old_val = mcause_q;
            ADDR_MTVAL:     old_val = mtval_q;
            ADDR_MCYCLE:    old_val = mcycle[31:0];
            ADDR_MCYCLEH:   old_val = mcycle[63:32];
            ADDR_MINSTRET:  old_val = minstret[31:0];
            ADDR_MINSTRETH: old_val = minstret[63:32];
`ifdef CSR_ZICNTR_EN
            ADDR_CYCLE, ADDR_TIME:   old_val = mcycle[31:0];
            ADDR_CYCLEH, ADDR_TIMEH: old_val = mcycle[63:32];
            ADDR_INSTRET:            old_val = minstret[31:0];
            ADDR_INSTRETH:           old_val = minstret[63:32];
`endif
            default:        impl = 1'b0;
        endcase
    end

    // 0xC-- space is read-only, so the alias writes fall out of the same check.
    assign csr_illegal = csr_req && (!impl || (csr_wen && csr_addr[11:10] == 2'b11));
    assign csr_rdata   = (csr_req && !csr_illegal) ? old_val : '0;

    // Trap and mret outrank an access in the same cycle and drop it.
    assign wr   = csr_req && !csr_illegal && csr_wen && (csr_op_t'(csr_op) != CSR_NONE)
                  && !trap_req && !mret_req;
    assign wval = csr_wval(csr_op_t'(csr_op), old_val, csr_wdata);

    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_bit_d = mpie_bit_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mie_d      = mie_q;
        if (trap_req) begin
            mepc_d     = trap_pc[31:2];
            mcause_d   = trap_cause;
            mtval_d    = trap_tval;
            mpie_bit_d = mie_bit_q;
            mie_bit_d  = 1'b0;
        end else if (mret_req) begin
            mie_bit_d  = mpie_bit_q;
            mpie_bit_d = 1'b1;
        end else if (wr) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie_bit_d  = wval[MSTATUS_MIE_BIT];
                    mpie_bit_d = wval[MSTATUS_MPIE_BIT];
                end
                ADDR_MTVEC:    mtvec_d    = wval[31:2];
                ADDR_MSCRATCH: mscratch_d = wval;
                ADDR_MEPC:     mepc_d     = wval[31:2];
                ADDR_MCAUSE:   mcause_d   = wval;
                ADDR_MTVAL:    mtval_d    = wval;
                ADDR_MIE:      mie_d      = wval & MIE_WMASK;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_bit_q  <= 1'b0;
            mpie_bit_q <= 1'b0;
            mtvec_q    <= RESET_MTVEC[31:2];
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mie_q      <= '0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_bit_q <= mpie_bit_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mie_q      <= mie_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .we_lo (wr && csr_addr == ADDR_MCYCLE),
        .we_hi (wr && csr_addr == ADDR_MCYCLEH),
        .wdata (wval),
        .cnt_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret_pulse),
        .we_lo (wr && csr_addr == ADDR_MINSTRET),
        .we_hi (wr && csr_addr == ADDR_MINSTRETH),
        .wdata (wval),
        .cnt_o (minstret)
    );

    assign trap_vector = {mtvec_q, 2'b00};
    assign mepc_o      = {mepc_q, 2'b00};
    assign mstatus_mie = mie_bit_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: vector table plus trap/mret/counter/reset sequences.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_req;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instret_pulse;
    logic        trap_req;
    logic [31:0] trap_pc, trap_cause, trap_tval;
    logic        mret_req;
    logic [31:0] trap_vector, mepc_o;
    logic        mstatus_mie;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    csr_file #(
        .HART_ID     (32'h0000_0005),
        .MISA_VALUE  (32'h4000_0100),
        .RESET_MTVEC (32'h8000_0103)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .csr_req       (csr_req),
        .csr_addr      (csr_addr),
        .csr_op        (csr_op),
        .csr_wen       (csr_wen),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .csr_illegal   (csr_illegal),
        .instret_pulse (instret_pulse),
        .trap_req      (trap_req),
        .trap_pc       (trap_pc),
        .trap_cause    (trap_cause),
        .trap_tval     (trap_tval),
        .mret_req      (mret_req),
        .trap_vector   (trap_vector),
        .mepc_o        (mepc_o),
        .mstatus_mie   (mstatus_mie)
    );

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic        wen;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [11:0] a, logic [1:0] o, logic w, logic [31:0] d,
                                logic c, logic [31:0] e, logic il);
        vec_t v;
        v.addr = a; v.op = o; v.wen = w; v.wd = d; v.chk = c; v.exp = e; v.ill = il;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic drive(logic [11:0] a, logic [1:0] o, logic w, logic [31:0] d);
        csr_req = 1'b1; csr_addr = a; csr_op = o; csr_wen = w; csr_wdata = d;
    endtask

    task automatic idle();
        csr_req = 1'b0; csr_addr = '0; csr_op = 2'b00; csr_wen = 1'b0; csr_wdata = '0;
        trap_req = 1'b0; mret_req = 1'b0; instret_pulse = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle read: drive, sample at negedge, commit at posedge.
    task automatic rd(string name, logic [11:0] a, logic [31:0] exp);
        drive(a, 2'b10, 1'b0, 32'h0);
        @(negedge clk);
        check(name, csr_rdata, exp);
        step();
        idle();
    endtask

    task automatic wr(logic [11:0] a, logic [31:0] d);
        drive(a, 2'b01, 1'b1, d);
        step();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        trap_pc = '0; trap_cause = '0; trap_tval = '0;
        idle();

        tbl.push_back(mk(12'h305, 2'b10, 0, 32'h0,         1, 32'h8000_0100, 0));
        tbl.push_back(mk(12'h300, 2'b10, 0, 32'h0,         1, 32'h0000_1800, 0));
        tbl.push_back(mk(12'h340, 2'b01, 1, 32'hDEAD_BEEF, 1, 32'h0,         0));
        tbl.push_back(mk(12'h340, 2'b10, 1, 32'h0000_0010, 1, 32'hDEAD_BEEF, 0));
        tbl.push_back(mk(12'h340, 2'b11, 1, 32'hF000_0000, 1, 32'hDEAD_BEFF, 0));
        tbl.push_back(mk(12'h340, 2'b10, 0, 32'h0,         1, 32'h0EAD_BEFF, 0));
        tbl.push_back(mk(12'hB00, 2'b01, 1, 32'hFFFF_FFFF, 0, 32'h0,         0));
        tbl.push_back(mk(12'hB80, 2'b01, 1, 32'h0,         0, 32'h0,         0));
        tbl.push_back(mk(12'hB00, 2'b10, 0, 32'h0,         1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(12'hB80, 2'b10, 0, 32'h0,         1, 32'h0000_0001, 0));
        tbl.push_back(mk(12'hB80, 2'b01, 1, 32'hFFFF_FFFF, 0, 32'h0,         0));
        tbl.push_back(mk(12'hB00, 2'b01, 1, 32'hFFFF_FFFF, 0, 32'h0,         0));
        tbl.push_back(mk(12'hB80, 2'b10, 0, 32'h0,         1, 32'hFFFF_FFFF, 0));
        tbl.push_back(mk(12'hB80, 2'b10, 0, 32'h0,         1, 32'h0,         0));
        tbl.push_back(mk(12'hB00, 2'b10, 0, 32'h0,         1, 32'h0000_0001, 0));
        tbl.push_back(mk(12'h7C0, 2'b10, 0, 32'h0,         1, 32'h0,         1));
        tbl.push_back(mk(12'hF14, 2'b01, 1, 32'h1,         1, 32'h0,         1));
        tbl.push_back(mk(12'hF14, 2'b10, 0, 32'h0,         1, 32'h0000_0005, 0));
        tbl.push_back(mk(12'h301, 2'b10, 0, 32'h0,         1, 32'h4000_0100, 0));
        tbl.push_back(mk(12'h304, 2'b01, 1, 32'hFFFF_FFFF, 1, 32'h0,         0));
        tbl.push_back(mk(12'h304, 2'b10, 0, 32'h0,         1, 32'h0000_0888, 0));
        tbl.push_back(mk(12'h344, 2'b10, 0, 32'h0,         1, 32'h0,         0));
        tbl.push_back(mk(12'h341, 2'b01, 1, 32'h0000_0123, 1, 32'h0,         0));
        tbl.push_back(mk(12'h341, 2'b10, 0, 32'h0,         1, 32'h0000_0120, 0));
        tbl.push_back(mk(12'h305, 2'b01, 1, 32'h0000_2003, 1, 32'h8000_0100, 0));
        tbl.push_back(mk(12'h305, 2'b10, 0, 32'h0,         1, 32'h0000_2000, 0));
        tbl.push_back(mk(12'h300, 2'b01, 1, 32'hFFFF_FFFF, 1, 32'h0000_1800, 0));
        tbl.push_back(mk(12'h300, 2'b01, 1, 32'h0,         1, 32'h0000_1888, 0));
        tbl.push_back(mk(12'h301, 2'b01, 1, 32'h0000_1234, 1, 32'h4000_0100, 0));
        tbl.push_back(mk(12'h301, 2'b10, 0, 32'h0,         1, 32'h4000_0100, 0));
        tbl.push_back(mk(12'hF11, 2'b10, 0, 32'h0,         1, 32'h0,         0));
        tbl.push_back(mk(12'h342, 2'b01, 1, 32'h0000_0007, 1, 32'h0,         0));
        tbl.push_back(mk(12'h342, 2'b10, 0, 32'h0,         1, 32'h0000_0007, 0));
`ifndef CSR_ZICNTR_EN
        tbl.push_back(mk(12'hC02, 2'b10, 0, 32'h0,         1, 32'h0,         1));
        tbl.push_back(mk(12'hC00, 2'b10, 0, 32'h0,         1, 32'h0,         1));
`endif

        // Reset state
        step();
        step();
        check("rst_mie", {31'b0, mstatus_mie}, 32'h0);
        check("rst_trap_vector", trap_vector, 32'h8000_0100);
        check("rst_mepc", mepc_o, 32'h0);
        rst = 1'b0;
        rd("mcycle_0", 12'hB00, 32'h0);
        rd("mcycle_1", 12'hB00, 32'h1);
        rd("mcycle_2", 12'hB00, 32'h2);

        foreach (tbl[i]) begin
            drive(tbl[i].addr, tbl[i].op, tbl[i].wen, tbl[i].wd);
            @(negedge clk);
            check($sformatf("vec%0d_ill", i), {31'b0, csr_illegal}, {31'b0, tbl[i].ill});
            if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), csr_rdata, tbl[i].exp);
            step();
        end
        idle();
        check("trap_vector_wr", trap_vector, 32'h0000_2000);
        check("mepc_o_wr", mepc_o, 32'h0000_0120);

        // Trap with a concurrent CSR write that must be dropped
        wr(12'h300, 32'h0000_0008);
        check("mie_set", {31'b0, mstatus_mie}, 32'h1);
        drive(12'h340, 2'b01, 1'b1, 32'h1234_5678);
        trap_req = 1'b1; trap_pc = 32'h0000_1006; trap_cause = 32'h2; trap_tval = 32'h13;
        step();
        idle();
        check("trap_mepc", mepc_o, 32'h0000_1004);
        check("trap_mie", {31'b0, mstatus_mie}, 32'h0);
        rd("trap_mcause", 12'h342, 32'h2);
        rd("trap_mtval", 12'h343, 32'h13);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);
        rd("trap_mscratch", 12'h340, 32'h0EAD_BEFF);

        // mret with a dropped mstatus write
        drive(12'h300, 2'b01, 1'b1, 32'h0);
        mret_req = 1'b1;
        step();
        idle();
        check("mret_mie", {31'b0, mstatus_mie}, 32'h1);
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // trap beats mret in the same cycle
        trap_req = 1'b1; mret_req = 1'b1; trap_pc = 32'h0000_2000;
        step();
        idle();
        check("trapmret_mepc", mepc_o, 32'h0000_2000);
        rd("trapmret_mstatus", 12'h300, 32'h0000_1880);

        // instret counting
        repeat (5) begin
            instret_pulse = 1'b1;
            step();
        end
        idle();
        rd("minstret_5", 12'hB02, 32'h5);
`ifdef CSR_ZICNTR_EN
        rd("instret_alias", 12'hC02, 32'h5);
        drive(12'hC00, 2'b01, 1'b1, 32'h0);
        @(negedge clk);
        check("cycle_wr_ill", {31'b0, csr_illegal}, 32'h1);
        check("cycle_wr_rdata", csr_rdata, 32'h0);
        step();
        idle();
`endif

        // Asynchronous reset in the middle of a pending write
        drive(12'h340, 2'b01, 1'b1, 32'h0000_0055);
        #2;
        rst = 1'b1;
        #1;
        check("async_mepc", mepc_o, 32'h0);
        step();
        idle();
        check("arst_trap_vector", trap_vector, 32'h8000_0100);
        check("arst_mie", {31'b0, mstatus_mie}, 32'h0);
        rst = 1'b0;
        rd("arst_mcycle", 12'hB00, 32'h0);
        rd("arst_mscratch", 12'h340, 32'h0);
        rd("arst_minstret", 12'hB02, 32'h0);
        rd("arst_mtvec", 12'h305, 32'h8000_0100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- RV32 machine-mode CSR register file. Consumes 12-bit CSR addresses and ops from the execute stage.
- Performs atomic read-modify-write for CSRRW/CSRRS/CSRRC.
- Maintains the 64-bit mcycle/minstret counters.
- Handles trap entry and mret state updates, and feeds the trap vector and mepc back to fetch.

Parameters:
- HART_ID, 32'h0, value returned by mhartid.
- MISA_VALUE, 32'h4000_0100, constant returned by misa (RV32I); writes ignored.
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset; bits [1:0] forced 0.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- csr_req  in  1  CSR instruction valid this cycle
- csr_addr  in  12  CSR address
- csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
- csr_wen  in  1  write intent; decoder drives 0 for RS/RC with rs1=x0
- csr_wdata  in  32  rs1 value or zero-extended uimm
- csr_rdata  out  32  old CSR value (combinational)
- csr_illegal  out  1  illegal-instruction indication (combinational)
- instret_pulse  in  1  one instruction retired this cycle
- trap_req  in  1  take trap this cycle
- trap_pc  in  32  faulting PC
- trap_cause  in  32  mcause value
- trap_tval  in  32  mtval value
- mret_req  in  1  mret retiring this cycle
- trap_vector  out  32  {mtvec[31:2],2'b00}
- mepc_o  out  32  current mepc
- mstatus_mie  out  1  global interrupt enable

Behaviour:
- Read path is combinational: csr_rdata = current (pre-write) value when csr_req; otherwise 0.
- Write commits at the next rising clk edge.
- Write value by op:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
  - No write if csr_wen=0 or csr_op=00.
- csr_illegal=1 when csr_req and either:
  - address is not implemented, or
  - csr_wen=1 and addr[11:10]==2'b11 (read-only).
- When illegal: csr_rdata=0 and no state changes from the CSR access.
- Implemented CSRs:
  - mvendorid/marchid/mimpid read 0; mhartid reads HART_ID; misa reads MISA_VALUE.
  - mstatus: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; all other bits 0.
  - mtvec: bits [1:0] read 0 (direct mode only).
  - mscratch: full 32 bits.
  - mepc: bits [1:0] read 0.
  - mcause, mtval: full 32 bits.
  - mie: only bits 3, 7, 11 writable. mip reads 0.
  - mcycle, mcycleh, minstret, minstreth: writable.
- Counters:
  - mcycle increments every cycle; minstret increments on instret_pulse.
  - 64-bit, carry from low to high word, wraps 2^64-1 -> 0.
  - Write to either half in the same cycle as an increment: the written half takes wdata, the other half holds, no increment that cycle for that counter.
- Trap entry (trap_req=1): mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0.
- mret (mret_req=1): MIE<=MPIE, MPIE<=1.
- Priority: trap_req > mret_req > CSR write. A lower-priority update in the same cycle is dropped entirely. Counter increments still occur.
- Reset (asynchronous, any time including mid-access):
  - all CSRs 0, except mtvec=RESET_MTVEC.
  - counters 0; mstatus_mie=0; trap_vector=RESET_MTVEC&~3; mepc_o=0.
  - No pending write survives reset.
- Write-to-readback latency is 1 cycle. A read in the cycle after a write returns the new value.

Optional Feature:
- Macro: CSR_ZICNTR_EN.
- Defined: user read-only aliases are implemented:
  - cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82 (time/timeh 0xC01/0xC81 return the cycle values).
  - Any write to them flags csr_illegal.
- Undefined: these addresses are unimplemented and csr_illegal=1 on any access.

Decomposition:
- Add to pkg_csr:
  - csr_op_t enum (CSR_NONE/RW/RS/RC).
  - MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7.
  - MIE_WMASK=32'h888.
  - user counter addresses CYCLE/TIME/INSTRET and the CYCLEH/TIMEH/INSTRETH high halves.
- Sub-module csr_counter64: 64-bit counter with inc enable, lo/hi write enables, write data. Instantiated twice (mcycle, minstret).

Test Plan:
- Reset, then read mtvec with RESET_MTVEC=32'h8000_0103 -> 32'h8000_0100. mstatus -> 32'h0000_1800. mcycle increments 0,1,2 on successive cycles.
- CSRRW mscratch 32'hDEAD_BEEF -> rdata 0. Then CSRRS mscratch 32'h0000_0010, then CSRRC mscratch 32'hF000_0000 -> rdata DEAD_BEEF then DEAD_BEFF. Final read 0EAD_BEFF.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0 -> next cycle mcycle=0, mcycleh=1. mcycleh=32'hFFFF_FFFF with mcycle=32'hFFFF_FFFF -> wraps to 0/0.
- Set MIE=1, then trap_req with pc 32'h0000_1006, cause 2, tval 32'h13 together with a CSRRW mscratch -> mepc=32'h1004, mcause=2, mtval=32'h13, MPIE=1, MIE=0, mscratch unchanged.
- Following mret_req -> MIE=1, MPIE=1.
- csr_req to 0x7C0 -> csr_illegal=1, rdata 0.
- CSRRW to mhartid -> illegal.
- CSRRS to mhartid with csr_wen=0 -> legal, rdata HART_ID.
- With CSR_ZICNTR_EN, read 0xC02 after 5 instret_pulses -> 5, and a write to 0xC00 -> illegal. Without the macro, a read of 0xC02 -> illegal.
